// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_param
// Brief    : Single-clock FIFO, any depth >= 2, with almost-full/empty,
//            occupancy count, synchronous flush and sticky error flags.
// Revision : 1.0  initial parametrised release
// ============================================================================
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_data,
    input  logic                       read_data,
    input  logic                       flush,
    input  logic                       clear_err,
    input  logic [WIDTH-1:0]           data_input,
    output logic [WIDTH-1:0]           data_output,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
    localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);
    localparam logic [CW-1:0] c_ae_level = CW'(AE_LEVEL);
    localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_do_rd;
    logic             w_do_wr;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    // Flags come straight from the registered count, so no request input
    // can reach them combinationally.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // A read frees a slot in the same edge, letting a write into a full FIFO.
    assign w_rd_ok = read_data && !w_empty;
    assign w_wr_ok = write_data && (!w_full || w_rd_ok);

    assign w_do_rd   = w_rd_ok && !flush;
    assign w_do_wr   = w_wr_ok && !flush;
    assign w_ovf_evt = write_data && !w_wr_ok && !flush;
    assign w_unf_evt = read_data && !w_rd_ok && !flush;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= data_input;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_dout      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_do_wr) begin
                    r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
                end
                if (w_do_rd) begin
                    r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
                    r_dout <= r_mem[r_rptr];
                end
                case ({w_do_wr, w_do_rd})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            // A new error in the same cycle as clear_err wins.
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (clear_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign data_output  = r_dout;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af_level);
    assign almost_empty = (r_count <= c_ae_level);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_param
// Brief    : Scoreboard bench for fifo_sync_param (WIDTH=8, DEPTH=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       write_data;
    logic       read_data;
    logic       flush;
    logic       clear_err;
    logic [7:0] data_input;
    logic [7:0] data_output;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    fifo_sync_param #(
        .WIDTH    (8),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_data   (write_data),
        .read_data    (read_data),
        .flush        (flush),
        .clear_err    (clear_err),
        .data_input   (data_input),
        .data_output  (data_output),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic cyc(input logic w, input logic r, input logic f, input logic ce,
                       input logic [7:0] d);
        write_data = w;
        read_data  = r;
        flush      = f;
        clear_err  = ce;
        data_input = d;
        @(posedge clk);
        @(negedge clk);
        write_data = 1'b0;
        read_data  = 1'b0;
        flush      = 1'b0;
        clear_err  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    // Every sampled read request yields an expected data_output one edge later
    // (the held value when the read is rejected).
    task automatic rd(input logic [7:0] exp);
        exp_q.push_back(exp);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    always @(posedge clk) begin
        if (rst && read_data && !flush) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_read", 32'(data_output), 32'hFFFF_FFFF);
            end else begin
                chk("sb_data_output", 32'(data_output), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        write_data = 1'b0;
        read_data  = 1'b0;
        flush      = 1'b0;
        clear_err  = 1'b0;
        data_input = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_dout", 32'(data_output), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // Ordering
        for (int i = 0; i < 8; i++) wr(8'h11 + 8'(i));
        chk("ord_count8", 32'(count), 8);
        for (int i = 0; i < 4; i++) rd(8'h11 + 8'(i));
        chk("ord_count4", 32'(count), 4);
        chk("ord_ae", 32'(almost_empty), 0);
        for (int i = 0; i < 4; i++) rd(8'h15 + 8'(i));
        chk("ord_empty", 32'(empty), 1);

        // Fill past full
        for (int i = 1; i <= 18; i++) begin
            wr(8'(i));
            if (i == 13) chk("fill_af_13", 32'(almost_full), 0);
            if (i == 14) chk("fill_af_14", 32'(almost_full), 1);
            if (i == 15) chk("fill_full_15", 32'(full), 0);
            if (i == 16) begin
                chk("fill_full_16", 32'(full), 1);
                chk("fill_ovf_16", 32'(overflow), 0);
            end
        end
        chk("fill_count", 32'(count), 16);
        chk("fill_ovf", 32'(overflow), 1);

        // Drain past empty: last two reads rejected, output holds 0x10
        for (int i = 1; i <= 18; i++) begin
            rd((i <= 16) ? 8'(i) : 8'h10);
            if (i == 15) chk("drain_empty_15", 32'(empty), 0);
            if (i == 16) begin
                chk("drain_empty_16", 32'(empty), 1);
                chk("drain_unf_16", 32'(underflow), 0);
            end
        end
        chk("drain_unf", 32'(underflow), 1);
        chk("drain_count", 32'(count), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_unf", 32'(underflow), 0);

        // Simultaneous access at full, across pointer wrap
        for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i));
        chk("sim_full", 32'(full), 1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
        end
        chk("sim_count", 32'(count), 16);
        chk("sim_ovf", 32'(overflow), 0);
        for (int i = 5; i < 16; i++) rd(8'hA0 + 8'(i));
        for (int i = 0; i < 5; i++) rd(8'hB0 + 8'(i));
        chk("sim_empty", 32'(empty), 1);

        // Simultaneous access at empty: only the write goes in
        exp_q.push_back(8'hB4);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        chk("sime_count", 32'(count), 1);
        chk("sime_unf", 32'(underflow), 1);
        rd(8'hC3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("sime_clr", 32'(underflow), 0);

        // Flush with a concurrent write
        for (int i = 0; i < 9; i++) wr(8'hD0 + 8'(i));
        chk("fl_count9", 32'(count), 9);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
        chk("fl_count", 32'(count), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_ovf", 32'(overflow), 0);
        chk("fl_dout_hold", 32'(data_output), 32'hC3);
        wr(8'h5A);
        rd(8'h5A);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
        chk("ar_count5", 32'(count), 5);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_ae", 32'(almost_empty), 1);
        chk("ar_dout", 32'(data_output), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar_after_empty", 32'(empty), 1);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Single-clock synchronous FIFO. Parametrised successor to the team's fixed 8-bit FIFO.
- Generalised in data width and depth, including non-power-of-two depths.
- Adds almost-full/almost-empty thresholds, an occupancy count output, simultaneous read/write at the boundaries, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer stages that share one clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries (>=2; need not be a power of two).
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- write_data  in  1  write request
- read_data  in  1  read request
- flush  in  1  synchronous clear of contents
- clear_err  in  1  synchronous clear of the sticky error flags
- data_input  in  WIDTH  write data
- data_output  out  WIDTH  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers, count, data_output, overflow and underflow all go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0); since AF_LEVEL>=1, almost_full=0.
  - Reset asserted mid-operation discards all contents immediately.
  - Storage array is not reset; its contents are don't-care.
- Acceptance, evaluated from pre-edge state:
  - wr_ok = write_data && (!full || rd_ok)
  - rd_ok = read_data && !empty
- Full boundary: with full and both requests high, both are accepted; count stays DEPTH.
- Empty boundary: with empty and both requests high, only the write is accepted; there is no fall-through and underflow sets.
- Write: mem[wptr] <= data_input; wptr advances and wraps from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
- Read: data_output <= mem[rptr] at the same edge; the value is visible one cycle after the request is sampled. rptr wraps the same way as wptr. data_output holds its value when no read is accepted.
- count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither are accepted
- Flags are all registered/derived from count and are valid the cycle after the causing edge; no combinational path from the request inputs to the flags.
- Error flags:
  - overflow sets when write_data && !wr_ok.
  - underflow sets when read_data && !rd_ok.
  - Both are sticky until clear_err=1 or reset.
  - If clear_err and a new error occur in the same cycle, the set wins.
- Flush (flush=1):
  - At the next edge, pointers and count go to 0 and all requests that cycle are ignored (no error flags set).
  - data_output holds its value; error flags are unaffected.
  - Flush has priority over reads and writes.
- Rejected operations leave storage, pointers and data_output unchanged.

Test Plan (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2):
- Reset: hold rst=0 for 2 cycles, then release → empty=1, count=0, data_output=0, almost_empty=1, overflow=0, underflow=0.
- Order: write 8 words 0x11..0x18, then read 4 → data_output shows 0x11, 0x12, 0x13, 0x14, each one cycle after its read request; count=4; almost_empty=0.
- Fill: from empty, write 18 words 0x01..0x12 → full=1 after the 16th; almost_full=1 from count=14; last 2 writes rejected; overflow=1; count=16. Then 16 reads return 0x01..0x10 in order.
- Drain past empty: read 18 times from count=16 → empty=1 after the 16th; underflow=1; data_output holds 0x10. Pulse clear_err → both error flags return to 0.
- Simultaneous access:
  - At full with read_data=write_data=1 for 5 cycles → count stays 16, no overflow, and order is preserved across pointer wrap.
  - At empty with both high → count=1, underflow=1.
- Flush and reset mid-run:
  - At count=9, assert flush together with write_data → count=0, empty=1, no overflow set.
  - At count=5, pulse rst=0 mid-cycle → outputs go to reset values immediately, before the next clock edge.
